// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Used by hazard_ctrl and its fwd_sel instances.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source select for one ALU operand in Execute.
// Memory stage result takes priority over Writeback.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && reg_match(rd_m, rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && reg_match(rd_w, rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stalls, branch flushes, operand forwarding,
// data-memory wait/timeout handling and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] wait_cnt_q;

  logic       mem_stall;
  logic       lw_stall;
  logic       freeze;
  logic       br_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  always_comb begin
    mem_stall = MemReqM & ~MemReadyM;
    lw_stall  = (ResultSrcE == RESULT_LOAD) && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));
    freeze    = mem_stall || (state_q == ERR);
  end

  // Priority: reset, memory freeze/error, taken branch, load-use. The cycle that
  // MemReadyM rises drops mem_stall, so normal hazards apply with no dead cycle.
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;
    br_flush = 1'b0;
    if (rst) begin
      br_flush = 1'b0;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      br_flush = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = rst ? FWD_RF : fwd_a;
    ForwardBE = rst ? FWD_RF : fwd_b;
  end

  // wait_cnt_q counts WAIT cycles; the timeout fires on the MEM_TIMEOUT-th stalled WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 4'd0;
      MemErr     <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          wait_cnt_q <= 4'd0;
          if (mem_stall) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            state_q    <= RUN;
            wait_cnt_q <= 4'd0;
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q <= ERR;
            MemErr  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        ERR: begin
          MemErr <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1)) begin
        StallCount <= StallCount + 1'b1;
      end
      if (br_flush && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 1'b1;
      end
    end
  end

endmodule
